// File: rtl/quad_pkg.sv
// -----------------------------------------------------------------------------
// quad_pkg
// Shared types for the quad_collector block and its neighbours:
//   DEFAULT_WIDTH  - default sample width in bits
//   coll_state_e   - collector state (FILL0..FILL3 = slot count, PEND = held)
//   window_t       - packed four-slot window, slot 0 = first/oldest sample
//   fill_state()   - maps a 2-bit slot count onto its FILLn state
// -----------------------------------------------------------------------------
package quad_pkg;

    localparam int DEFAULT_WIDTH = 2;

    typedef enum logic [2:0] {
        FILL0 = 3'd0,
        FILL1 = 3'd1,
        FILL2 = 3'd2,
        FILL3 = 3'd3,
        PEND  = 3'd4
    } coll_state_e;

    typedef logic [3:0][DEFAULT_WIDTH-1:0] window_t;

    function automatic coll_state_e fill_state(input logic [1:0] n);
        case (n)
            2'd0:    return FILL0;
            2'd1:    return FILL1;
            2'd2:    return FILL2;
            default: return FILL3;
        endcase
    endfunction

endpackage

// File: rtl/quad_collector.sv
// -----------------------------------------------------------------------------
// quad_collector
// Groups a serial valid/ready sample stream into windows of four and presents
// each window in parallel for the downstream min/max selector. A window cut
// short by in_last is padded with its final sample so min/max is unaffected.
// Collection slots (s) are separate from the output registers (a..d), so the
// next window is gathered while the current one waits downstream.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_data/in_valid/in_last/in_ready   serial input handshake (in_ready is
//                                       registered, no combinational input path)
//   a, b, c, d            window samples in arrival order
//   out_valid/out_last/out_ready        parallel output handshake
//
// Build option:
//   QUAD_COLLECTOR_SLIDE_EN  sliding window: slots form a shift register and,
//                            once four samples are held, every accept closes a
//                            window. Undefined: non-overlapping block windows.
// -----------------------------------------------------------------------------
module quad_collector
    import quad_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready
);

    typedef logic [3:0][WIDTH-1:0] slots_t;

    coll_state_e state_q, state_d;
    slots_t      s_q, s_d;
    slots_t      out_q, out_d;
    logic        out_valid_q, out_valid_d;
    logic        out_last_q, out_last_d;
    logic        pend_last_q, pend_last_d;
    logic        in_ready_q, in_ready_d;

    logic        accept;
    logic        out_free;
    logic        close;
    logic [1:0]  cnt;
    slots_t      win;

    assign accept   = in_valid && in_ready_q;
    assign out_free = !out_valid_q || out_ready;
    assign cnt      = (state_q == PEND) ? 2'd0 : state_q[1:0];
    assign close    = accept && (in_last || cnt == 2'd3);

    // Window as it would look after the current sample is taken in.
`ifdef QUAD_COLLECTOR_SLIDE_EN
    logic [1:0] lead;
    slots_t     shifted;

    always_comb begin
        shifted    = s_q;
        shifted[0] = s_q[1];
        shifted[1] = s_q[2];
        shifted[2] = s_q[3];
        shifted[3] = in_data;
        // Valid samples occupy slots lead..3; empty leading slots repeat the
        // oldest valid one so a short frame stays right-aligned.
        lead = ~cnt;
        win  = shifted;
        if (in_last) begin
            for (int i = 0; i < 4; i++) begin
                if (i < int'(lead)) begin
                    win[i] = shifted[lead];
                end
            end
        end
    end
`else
    always_comb begin
        win      = s_q;
        win[cnt] = in_data;
        // Early close: unfilled slots repeat the final sample.
        if (in_last) begin
            for (int i = 0; i < 4; i++) begin
                if (i > int'(cnt)) begin
                    win[i] = in_data;
                end
            end
        end
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= FILL0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            pend_last_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            pend_last_q <= pend_last_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Slot contents are qualified by the state, so they need no reset.
    always_ff @(posedge clk) begin
        s_q <= s_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            PEND: begin
                if (out_free) begin
`ifdef QUAD_COLLECTOR_SLIDE_EN
                    state_d = pend_last_q ? FILL0 : FILL3;
`else
                    state_d = FILL0;
`endif
                end
            end
            default: begin
                if (close) begin
                    if (!out_free) begin
                        state_d = PEND;
                    end else begin
`ifdef QUAD_COLLECTOR_SLIDE_EN
                        state_d = in_last ? FILL0 : FILL3;
`else
                        state_d = FILL0;
`endif
                    end
                end else if (accept) begin
                    state_d = fill_state(cnt + 2'd1);
                end
            end
        endcase
    end

    // Output / datapath logic
    always_comb begin
        s_d         = s_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        pend_last_d = pend_last_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (state_q == PEND) begin
            if (out_free) begin
                out_d       = s_q;
                out_valid_d = 1'b1;
                out_last_d  = pend_last_q;
            end
        end else if (accept) begin
            s_d = win;
            if (close) begin
                if (out_free) begin
                    // Also covers a same-cycle present: the new window
                    // overwrites the departing one with no bubble.
                    out_d       = win;
                    out_valid_d = 1'b1;
                    out_last_d  = in_last;
                end else begin
                    pend_last_d = in_last;
                end
            end
        end

        in_ready_d = (state_d != PEND);
    end

    assign in_ready  = in_ready_q;
    assign a         = out_q[0];
    assign b         = out_q[1];
    assign c         = out_q[2];
    assign d         = out_q[3];
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_quad_collector.sv
// -----------------------------------------------------------------------------
// tb_quad_collector
// Directed bench for quad_collector in its default (block window) build.
// -----------------------------------------------------------------------------
module tb_quad_collector;
    import quad_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [W-1:0] a, b, c, d;
    logic         out_valid;
    logic         out_last;
    logic         out_ready;

    int vectors     = 0;
    int miscompares = 0;

    quad_collector #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic window_t mk(input logic [W-1:0] wa, input logic [W-1:0] wb,
                                   input logic [W-1:0] wc, input logic [W-1:0] wd);
        window_t w;
        w[0] = wa;
        w[1] = wb;
        w[2] = wc;
        w[3] = wd;
        return w;
    endfunction

    function automatic window_t obs_win();
        return mk(a, b, c, d);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [W-1:0] v, input logic l);
        in_valid = 1'b1;
        in_data  = v;
        in_last  = l;
        tick();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    logic [W-1:0] seq1 [8];

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        idle();

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_window", 32'(obs_win()), 32'(mk(0, 0, 0, 0)));
        rst_n = 1'b1;
        tick();
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        // Full windows back-to-back, no back-pressure
        seq1 = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0};
        for (int i = 0; i < 8; i++) begin
            send(seq1[i], 1'b0);
            if (i == 3) begin
                chk("w1_valid", 32'(out_valid), 32'd1);
                chk("w1_data", 32'(obs_win()), 32'(mk(1, 3, 0, 2)));
                chk("w1_last", 32'(out_last), 32'd0);
            end else if (i == 7) begin
                chk("w2_valid", 32'(out_valid), 32'd1);
                chk("w2_data", 32'(obs_win()), 32'(mk(3, 2, 1, 0)));
                chk("w2_last", 32'(out_last), 32'd0);
            end else begin
                chk("gap_valid", 32'(out_valid), 32'd0);
            end
            chk("stream_in_ready", 32'(in_ready), 32'd1);
        end
        idle();
        tick();
        chk("drain_valid", 32'(out_valid), 32'd0);

        // Padding of a short frame, next window fresh at a
        send(2'd2, 1'b0);
        send(2'd1, 1'b1);
        chk("pad_valid", 32'(out_valid), 32'd1);
        chk("pad_data", 32'(obs_win()), 32'(mk(2, 1, 1, 1)));
        chk("pad_last", 32'(out_last), 32'd1);
        send(2'd3, 1'b1);
        chk("pad1_data", 32'(obs_win()), 32'(mk(3, 3, 3, 3)));
        chk("pad1_valid", 32'(out_valid), 32'd1);
        // in_last on the fourth sample is a normal full window
        send(2'd0, 1'b0);
        send(2'd1, 1'b0);
        send(2'd2, 1'b0);
        send(2'd3, 1'b1);
        chk("last4_data", 32'(obs_win()), 32'(mk(0, 1, 2, 3)));
        chk("last4_last", 32'(out_last), 32'd1);
        idle();
        tick();
        chk("last4_drain", 32'(out_valid), 32'd0);

        // Back-pressure: first window held, second goes pending
        out_ready = 1'b0;
        send(2'd0, 1'b0);
        send(2'd1, 1'b0);
        send(2'd2, 1'b0);
        send(2'd3, 1'b0);
        chk("bp_w1_valid", 32'(out_valid), 32'd1);
        chk("bp_w1_data", 32'(obs_win()), 32'(mk(0, 1, 2, 3)));
        send(2'd3, 1'b0);
        send(2'd2, 1'b0);
        send(2'd1, 1'b0);
        chk("bp_ready_7", 32'(in_ready), 32'd1);
        send(2'd0, 1'b0);
        chk("bp_ready_drop", 32'(in_ready), 32'd0);
        chk("bp_w1_hold", 32'(obs_win()), 32'(mk(0, 1, 2, 3)));
        send(2'd1, 1'b1);   // offered while pending; must not be taken
        chk("bp_ready_low", 32'(in_ready), 32'd0);
        chk("bp_w1_hold2", 32'(obs_win()), 32'(mk(0, 1, 2, 3)));
        chk("bp_last_hold", 32'(out_last), 32'd0);
        idle();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_w2_valid", 32'(out_valid), 32'd1);
        chk("bp_w2_data", 32'(obs_win()), 32'(mk(3, 2, 1, 0)));
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        tick();
        chk("bp_w2_hold", 32'(obs_win()), 32'(mk(3, 2, 1, 0)));
        out_ready = 1'b1;
        tick();
        chk("bp_drain", 32'(out_valid), 32'd0);

        // Reset mid-window
        send(2'd1, 1'b0);
        send(2'd1, 1'b0);
        idle();
        rst_n = 1'b0;
        tick();
        chk("mrst_in_ready", 32'(in_ready), 32'd0);
        chk("mrst_window", 32'(obs_win()), 32'(mk(0, 0, 0, 0)));
        chk("mrst_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("mrst_ready_up", 32'(in_ready), 32'd1);
        send(2'd2, 1'b0);
        send(2'd0, 1'b0);
        send(2'd1, 1'b0);
        chk("mrst_no_early", 32'(out_valid), 32'd0);
        send(2'd3, 1'b0);
        chk("mrst_data", 32'(obs_win()), 32'(mk(2, 0, 1, 3)));
        chk("mrst_valid2", 32'(out_valid), 32'd1);

        // Same-cycle close and present: no bubble
        send(2'd2, 1'b1);
        chk("sc_valid1", 32'(out_valid), 32'd1);
        chk("sc_data1", 32'(obs_win()), 32'(mk(2, 2, 2, 2)));
        send(2'd1, 1'b1);
        chk("sc_valid2", 32'(out_valid), 32'd1);
        chk("sc_data2", 32'(obs_win()), 32'(mk(1, 1, 1, 1)));
        chk("sc_ready", 32'(in_ready), 32'd1);
        idle();
        tick();
        chk("sc_drain", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/quad_collector.md
# quad_collector

Upstream feeder for the four-input min/max selector: accepts a serial stream of WIDTH-bit samples over a valid/ready handshake, groups them into windows of four, and presents each window in parallel on a, b, c, d with its own valid/ready handshake. A partial window, ended early by in_last, is padded by repeating its final sample, so the downstream min or max is unaffected. Output registers are separate from collection registers, so collection of the next window overlaps presentation of the current one.

## Interface
- WIDTH, 2, sample width in bits.
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- in_data  input  WIDTH  incoming sample.
- in_valid  input  1  in_data is valid.
- in_last  input  1  sample is the last of a frame; qualified by in_valid.
- in_ready  output  1  block accepts a sample this cycle; registered.
- a, b, c, d  output  WIDTH  window samples, in arrival order (first→a ... fourth→d).
- out_valid  output  1  a..d hold a complete window.
- out_last  output  1  window was closed by in_last.
- out_ready  input  1  downstream takes the window this cycle.

## Operation
- Accept: in_valid && in_ready. Present: out_valid && out_ready.
- Collection uses slot registers s0..s3 and a 2-bit count cnt (0..3).
- Each accept writes in_data to s[cnt] and increments cnt.
- A window closes on the accept that fills s3, or on any accept with in_last=1.
- Padding on close by in_last with k valid samples (k = 1..4): slots k..3 take that last sample's value.
- On close, cnt returns to 0.
- Close with output free (!out_valid || out_ready): the window loads into a..d next edge; out_valid=1; out_last=in_last.
- Close with output busy: set pending. Hold the window in s0..s3. in_ready drops next cycle.
- pending && output free: transfer s0..s3 to a..d, clear pending; in_ready returns high the following cycle.
- in_ready_next = !pending_next.
- The accept that sets pending is allowed. No further accept occurs until pending clears.
- States:
  - FILL0..FILL3: cnt value, pending=0.
  - PEND: window held.
  - Transitions:
    - FILLn→FILLn+1 on accept without close.
    - FILLn→FILL0 on close with output free.
    - FILLn→PEND on close with output busy.
    - PEND→FILL0 when output frees.
- a..d, out_last and out_valid are stable while out_valid && !out_ready.
- Reset:
  - All of these are 0: a, b, c, d, out_valid, out_last, in_ready, cnt, pending.
  - A partial window or pending window is discarded.
  - in_ready rises on the first edge with rst_n high.

## Timing
- Latency: out_valid rises on the edge after the closing accept.
- Throughput: one sample per cycle sustained while out_ready=1 (one window per 4 cycles; one per cycle in sliding mode).
- Simultaneous closing accept and present in the same cycle:
  - The new window replaces the old one.
  - out_valid stays 1.
  - No bubble.
- out_ready must not be combinationally dependent on in_valid (no loop); in_ready has no combinational path from any input.
- in_last=1 on the 4th sample: a normal full window with out_last=1.

## Configuration
- QUAD_COLLECTOR_SLIDE_EN defined: sliding window.
  - s0..s3 form a shift register: new sample into s3, s0 dropped.
  - After warm-up (4 accepts since reset or since the last in_last), every accept is a close: window (a,b,c,d) = (oldest..newest).
  - in_last before warm-up completes: the window is right-aligned. Valid samples fill from d backwards, and empty leading slots take the oldest valid sample.
  - in_last always resets warm-up.
  - Busy-output and pending rules are unchanged.
- Macro undefined: non-overlapping block windows as described in Operation.

## Structure
- Shared package quad_pkg:
  - DEFAULT_WIDTH constant.
  - Collector state enum (FILL0..FILL3, PEND).
  - Packed window typedef holding four WIDTH-bit slots.
- No sub-module: slot registers, counter and handshake are inline. The min/max selector is instantiated one level up, not inside this block.

## Test plan
- Full windows, no back-pressure, out_ready=1.
  - Stimulus: samples 1,3,0,2,3,2,1,0 back-to-back.
  - Response: a..d=1,3,0,2 with out_valid the cycle after the 4th accept, then 3,2,1,0 four cycles later; out_last=0.
- Padding.
  - Stimulus: 2 then 1 with in_last on the second.
  - Response: a..d=2,1,1,1, out_last=1.
  - Next window starts fresh at a.
- Back-pressure with out_ready=0.
  - Stimulus: eight samples.
  - Response:
    - The first window stays held.
    - The second window is held in PEND.
    - in_ready=0 after the 8th accept.
    - When out_ready=1 for one cycle, the second window appears next cycle and in_ready returns.
- Reset mid-operation.
  - Stimulus: rst_n=0 after 2 samples.
  - Response:
    - All outputs are 0 and in_ready=0 during reset.
    - Next window after reset starts at a; the old samples never appear.
- Same-cycle close and present.
  - Stimulus: closing accept while out_valid && out_ready.
  - Response: out_valid stays 1, the new window appears next cycle, with no idle cycle.
- With QUAD_COLLECTOR_SLIDE_EN, in_last=0 throughout.
  - Stimulus: 0,1,2,3,0.
  - Response: windows (0,1,2,3) then (1,2,3,0) on consecutive cycles.
